// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: MD multi-cycle ops, LSU grant wait with timeout, load-use and jump squash.
// Stall/flush outputs are combinational from state+inputs; md_start_o/lsu_timeout_o are registered.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT     = 2,
    parameter int DIV_LAT     = 33,
    parameter int LSU_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_rd_wr_en_i,
    input  logic       ex_lsu_req_i,
    input  logic       ex_lsu_we_i,
    input  logic       lsu_gnt_i,
    input  logic       ex_md_sel_i,
    input  logic       ex_md_div_i,
    input  logic       jump_taken_i,
    output logic       stall_if_o,
    output logic       stall_id_ex_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic       md_start_o,
    output logic       md_busy_o,
    output logic       lsu_timeout_o,
    output logic [1:0] ctrl_state_o
);

    localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MD_CW  = $clog2(MD_MAX) + 1;
    localparam int LSU_CW = $clog2(LSU_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MD_BUSY  = 2'd1,
        ST_LSU_WAIT = 2'd2
    } state_e;

    state_e              state, state_n;
    logic [MD_CW-1:0]    md_cnt, md_cnt_n;
    logic [LSU_CW-1:0]   lsu_cnt, lsu_cnt_n;
    logic                md_start_n;
    logic                timeout_n;
    logic                ex_stall;
    logic                lu_stall;
    logic                load_use;

    assign load_use = ex_lsu_req_i && !ex_lsu_we_i && ex_rd_wr_en_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        state_n       = state;
        md_cnt_n      = md_cnt;
        lsu_cnt_n     = lsu_cnt;
        md_start_n    = 1'b0;
        ex_stall      = 1'b0;
        lu_stall      = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ex_md_sel_i) begin
                    ex_stall   = 1'b1;
                    md_start_n = 1'b1;
                    state_n    = ST_MD_BUSY;
                    md_cnt_n   = ex_md_div_i ? MD_CW'(DIV_LAT - 1) : MD_CW'(MUL_LAT - 1);
                end else if (ex_lsu_req_i && !lsu_gnt_i) begin
                    ex_stall  = 1'b1;
                    state_n   = ST_LSU_WAIT;
                    lsu_cnt_n = LSU_CW'(1);
                end else if (load_use && lsu_gnt_i) begin
                    lu_stall      = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                if (md_cnt != '0) begin
                    ex_stall = 1'b1;
                    md_cnt_n = md_cnt - MD_CW'(1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LSU_WAIT: begin
                // The abort cycle is committed one edge ahead so lsu_timeout_o can be a flop;
                // a grant arriving in that very cycle is ignored and the access is squashed.
                if (lsu_timeout_o) begin
                    flush_id_ex_o = 1'b1;
                    state_n       = ST_IDLE;
                    lsu_cnt_n     = '0;
                end else if (lsu_gnt_i) begin
                    state_n   = ST_IDLE;
                    lsu_cnt_n = '0;
                end else begin
                    ex_stall  = 1'b1;
                    lsu_cnt_n = lsu_cnt + LSU_CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A taken jump only acts once EX is free to move; it overrides a load-use hold.
        if (jump_taken_i && !ex_stall) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            lu_stall      = 1'b0;
        end

        stall_id_ex_o = ex_stall;
        stall_if_o    = ex_stall | lu_stall;
    end

    assign timeout_n    = (state_n == ST_LSU_WAIT) && (lsu_cnt_n == LSU_CW'(LSU_TIMEOUT - 1));
    assign md_busy_o    = (state == ST_MD_BUSY);
    assign ctrl_state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            md_cnt        <= '0;
            lsu_cnt       <= '0;
            md_start_o    <= 1'b0;
            lsu_timeout_o <= 1'b0;
        end else begin
            state         <= state_n;
            md_cnt        <= md_cnt_n;
            lsu_cnt       <= lsu_cnt_n;
            md_start_o    <= md_start_n;
            lsu_timeout_o <= timeout_n;
        end
    end

endmodule
